// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that reuses one 4-bit lookahead slice, one nibble per clock, LSB first
// Ports: clock/reset (async, active-high); in_valid/in_ready + a, b, c_in accept operands;
//        out_valid/out_ready present sum, c_out, ovf; busy is high while nibbles are being added.
// Build option: NSA_OVERFLOW_EN enables the signed-overflow flag; without it ovf is tied to 0.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int IDX_W = NIB > 1 ? $clog2(NIB) : 1;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic carry_q, carry_d, c_out_q, c_out_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0] an, bn, p, g, s;
    logic [4:0] c;
    logic last, accept;
    assign in_ready  = state_q == IDLE;
    assign busy      = state_q == ADD;
    assign out_valid = state_q == DONE;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign accept    = in_ready && in_valid;
    assign last      = idx_q == IDX_W'(NIB - 1);
    always_comb begin
        an = a_q[{idx_q, 2'b00} +: 4];
        bn = b_q[{idx_q, 2'b00} +: 4];
        p = an ^ bn;
        g = an & bn;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s = p ^ c[3:0];
    end
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = c_in;
            idx_d   = '0;
            sum_d   = '0;
            c_out_d = 1'b0;
            state_d = ADD;
        end else if (state_q == ADD) begin
            sum_d[{idx_q, 2'b00} +: 4] = s;
            carry_d = c[4];
            idx_d   = last ? '0 : idx_q + 1'b1;
            c_out_d = last ? c[4] : c_out_q;
            state_d = last ? DONE : ADD;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
        end
    end
`ifdef NSA_OVERFLOW_EN
    logic ovf_q, ovf_d;
    // on the top nibble c[3] is the carry into bit WIDTH-1, c[4] the carry out of it
    always_comb begin
        ovf_d = ovf_q;
        if (accept) ovf_d = 1'b0;
        else if (state_q == ADD && last) ovf_d = c[3] ^ c[4];
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) ovf_q <= 1'b0;
        else ovf_q <= ovf_d;
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif
endmodule
